md_bus_resolver: RTL

Parametrised, registered resolver for a shared board-level bus driven by several sources, each presenting a value/release pair (release = 1 means "not driving"). It generalises the per-net resolution done inline in the board top level. It adds the following:
- selectable undriven behaviour: keeper, pull-up, or open-drain wired-AND;
- per-bit contention detection, with sticky flags, a saturating conflict counter and first-offender capture for debug.

One instance replaces each hand-written VD/VA/ZD/ZA-style resolver.

---
 rtl/md_bus_resolver.sv | 117 +++++++++++
 1 files changed

// File: rtl/md_bus_resolver.sv
`default_nettype none
// ============================================================================
// Module   : md_bus_resolver
// Purpose  : Registered resolver for a multi-source shared bus with keeper,
//            pull-up or wired-AND combining and contention debug capture.
// Revision : 1.0 - initial release
// ============================================================================
module md_bus_resolver #(
    parameter int                 WIDTH     = 16,
    parameter int                 DRIVERS   = 4,
    parameter int                 MODE      = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic                       MCLK,
    input  logic                       reset,
    input  logic [DRIVERS*WIDTH-1:0]   drv_o,
    input  logic [DRIVERS*WIDTH-1:0]   drv_d,
    input  logic                       clear,
    output logic [WIDTH-1:0]           bus,
    output logic [WIDTH-1:0]           bus_driven,
    output logic                       contention_now,
    output logic [WIDTH-1:0]           contention,
    output logic [CNT_W-1:0]           conflict_cnt,
    output logic [DRIVERS-1:0]         first_drivers
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0]   w_any0;
    logic [WIDTH-1:0]   w_any1;
    logic [WIDTH-1:0]   w_driven;
    logic [WIDTH-1:0]   w_conf;
    logic [WIDTH-1:0]   w_next;
    logic [DRIVERS-1:0] w_mask;
    logic               w_any_conf;

    logic [WIDTH-1:0]   r_bus;
    logic [WIDTH-1:0]   r_driven;
    logic               r_now;
    logic [WIDTH-1:0]   r_cont;
    logic [CNT_W-1:0]   r_cnt;
    logic [DRIVERS-1:0] r_first;

    always_comb begin
        w_any0   = '0;
        w_any1   = '0;
        w_driven = '0;
        for (int k = 0; k < DRIVERS; k++) begin
            w_driven = w_driven | ~drv_d[k*WIDTH +: WIDTH];
            w_any1   = w_any1 | (~drv_d[k*WIDTH +: WIDTH] &  drv_o[k*WIDTH +: WIDTH]);
            w_any0   = w_any0 | (~drv_d[k*WIDTH +: WIDTH] & ~drv_o[k*WIDTH +: WIDTH]);
        end
    end

    generate
        if (MODE == 2) begin : g_wired_and
            // Any active low wins; an empty active set floats high.
            assign w_next = ~w_any0;
            assign w_conf = '0;
        end else if (MODE == 1) begin : g_pull_up
            assign w_next = (w_driven & w_any1) | ~w_driven;
            assign w_conf = w_any0 & w_any1;
        end else begin : g_keeper
            assign w_next = (w_driven & w_any1) | (~w_driven & r_bus);
            assign w_conf = w_any0 & w_any1;
        end
    endgenerate

    assign w_any_conf = |w_conf;

    // Drivers touching any conflicting bit this cycle.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < DRIVERS; k++) begin
            w_mask[k] = |(~drv_d[k*WIDTH +: WIDTH] & w_conf);
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_bus    <= RESET_VAL;
            r_driven <= '0;
            r_now    <= 1'b0;
            r_cont   <= '0;
            r_cnt    <= '0;
            r_first  <= '0;
        end else begin
            r_bus    <= w_next;
            r_driven <= w_driven;
            r_now    <= w_any_conf;
            if (clear) begin
                // A conflict in the clearing cycle becomes the new first event.
                r_cont  <= w_conf;
                r_cnt   <= w_any_conf ? CNT_W'(1) : '0;
                r_first <= w_any_conf ? w_mask : '0;
            end else begin
                r_cont <= r_cont | w_conf;
                if (w_any_conf && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_any_conf && (r_first == '0)) begin
                    r_first <= w_mask;
                end
            end
        end
    end

    assign bus            = r_bus;
    assign bus_driven     = r_driven;
    assign contention_now = r_now;
    assign contention     = r_cont;
    assign conflict_cnt   = r_cnt;
    assign first_drivers  = r_first;

endmodule
`default_nettype wire
